// File: rtl/gp_reg_file.sv
// gp_reg_file: NUM_REGS x DATA_W general-purpose register storage.
// Full/low-half/high-half writes with ack/err pulses, a registered read
// port, and a clear-all sweep that zeroes one entry per cycle.
// Optional build macro: GP_REG_FILE_BYPASS_EN forwards a same-cycle
// accepted write to the read port (lane-merged). Without it, a read in
// the same cycle as a write to that address returns the pre-write value.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | writes accepted, reg_clr starts a sweep
// CLEAR  | zeroing entry clr_idx_q each cycle; writes ignored, reads live

module gp_reg_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        hl_sel,
  input  logic              reg_wr,
  output logic              reg_wr_ack,
  output logic              wr_err,
  input  logic              reg_clr,
  output logic              clr_busy,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid
);

  localparam int                HALF       = DATA_W / 2;
  // one extra bit so NUM_REGS == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   clr_idx_q;
  logic [DATA_W-1:0]   mem_q [NUM_REGS];

  logic                is_idle;
  logic                wr_in_range;
  logic                wr_legal;
  logic                wr_accept;
  logic                wr_reject;
  logic [DATA_W-1:0]   wr_old;
  logic [DATA_W-1:0]   wr_word;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rd_fwd;

  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [1:0]        mode
  );
    logic [DATA_W-1:0] res;
    case (mode)
      2'b00:   res = new_v;
      2'b01:   res = {old_v[DATA_W-1:HALF], new_v[HALF-1:0]};
      2'b10:   res = {new_v[DATA_W-1:HALF], old_v[HALF-1:0]};
      default: res = old_v;
    endcase
    return res;
  endfunction

  // write qualification; writes during a sweep are dropped without err
  always_comb begin
    is_idle     = (state_q == ST_IDLE);
    wr_in_range = ({1'b0, wr_addr} < NUM_REGS_X);
    wr_legal    = wr_in_range && (hl_sel != 2'b11);
    wr_accept   = reg_wr && is_idle && wr_legal;
    wr_reject   = reg_wr && is_idle && !wr_legal;
  end

  // current contents at the write address, merged with the new lanes
  always_comb begin
    wr_old = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_addr == ADDR_W'(i)) begin
        wr_old = mem_q[i];
      end
    end
    wr_word = lane_merge(wr_old, data_in, hl_sel);
  end

  // live read mux; out-of-range addresses fall through to zero
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_word = mem_q[i];
      end
    end
  end

  // optional write-to-read forwarding
  always_comb begin
`ifdef GP_REG_FILE_BYPASS_EN
    if (wr_accept && (wr_addr == rd_addr)) begin
      rd_fwd = lane_merge(rd_word, data_in, hl_sel);
    end else begin
      rd_fwd = rd_word;
    end
`else
    rd_fwd = rd_word;
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and busy flag
  always_comb begin
    state_d  = state_q;
    clr_busy = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (reg_clr) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        clr_busy = 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // sweep index: advances only while clearing, wraps to 0 on exit
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      clr_idx_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      if (clr_idx_q == LAST_IDX) begin
        clr_idx_q <= '0;
      end else begin
        clr_idx_q <= clr_idx_q + ADDR_W'(1);
      end
    end
  end

  // storage: sweep zeroing, or an accepted write (mutually exclusive by state)
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if ((state_q == ST_CLEAR) && (clr_idx_q == ADDR_W'(i))) begin
          mem_q[i] <= '0;
        end else if (wr_accept && (wr_addr == ADDR_W'(i))) begin
          mem_q[i] <= wr_word;
        end
      end
    end
  end

  // response pulses and registered read data
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      reg_wr_ack <= 1'b0;
      wr_err     <= 1'b0;
      rd_valid   <= 1'b0;
      data_out   <= '0;
    end else begin
      reg_wr_ack <= wr_accept;
      wr_err     <= wr_reject;
      rd_valid   <= rd_en;
      if (rd_en) begin
        data_out <= rd_fwd;
      end
    end
  end

endmodule

// File: tb/tb_gp_reg_file.sv
// Scoreboard bench for gp_reg_file (NUM_REGS=8, ADDR_W=4 so addresses 8..15
// are out of range). Stimulus pushes expected responses into queues; a
// negedge monitor pops them when the DUT presents ack/err/read data.

module tb_gp_reg_file;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 4;

  logic              clk;
  logic              rst_b;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] data_in;
  logic [1:0]        hl_sel;
  logic              reg_wr;
  logic              reg_wr_ack;
  logic              wr_err;
  logic              reg_clr;
  logic              clr_busy;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;

  gp_reg_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_b(rst_b), .wr_addr(wr_addr), .data_in(data_in),
    .hl_sel(hl_sel), .reg_wr(reg_wr), .reg_wr_ack(reg_wr_ack), .wr_err(wr_err),
    .reg_clr(reg_clr), .clr_busy(clr_busy), .rd_addr(rd_addr), .rd_en(rd_en),
    .data_out(data_out), .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tag;
    logic [31:0] data;
  } ev_t;

  int  ack_q[$];
  int  err_q[$];
  ev_t rd_q[$];
  ev_t busy_q[$];

  int n_pass  = 0;
  int n_total = 0;

  // reference model: contents plus "how many sweep cycles remain"
  logic [31:0] model_mem [NUM_REGS];
  int          busy_left;
  int          sweep_idx;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [1:0] mode);
    case (mode)
      2'd0:    return new_v;
      2'd1:    return (old_v & 32'hFFFF_0000) | (new_v & 32'h0000_FFFF);
      2'd2:    return (new_v & 32'hFFFF_0000) | (old_v & 32'h0000_FFFF);
      default: return old_v;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) model_mem[i] = '0;
    busy_left = 0;
    sweep_idx = 0;
    ack_q.delete();
    err_q.delete();
    rd_q.delete();
    busy_q.delete();
  endtask

  // one clock of stimulus; expectations are tagged with the edge they follow
  task automatic step(input logic wr, input logic [3:0] wa, input logic [31:0] d,
                      input logic [1:0] hl, input logic clr, input logic rd,
                      input logic [3:0] ra);
    int          tag;
    bit          legal;
    bit          acc;
    bit          ill;
    logic [31:0] v;
    @(posedge clk);
    #2;
    reg_wr  = wr;
    wr_addr = wa;
    data_in = d;
    hl_sel  = hl;
    reg_clr = clr;
    rd_en   = rd;
    rd_addr = ra;
    tag     = cyc + 1;
    legal   = (int'(wa) < NUM_REGS) && (hl != 2'd3);
    acc     = wr && (busy_left == 0) && legal;
    ill     = wr && (busy_left == 0) && !legal;
    if (rd) begin
      v = (int'(ra) < NUM_REGS) ? model_mem[int'(ra)] : 32'h0;
`ifdef GP_REG_FILE_BYPASS_EN
      if (acc && (wa == ra)) v = merge(v, d, hl);
`endif
      rd_q.push_back('{tag, v});
    end
    if (busy_left > 0) begin
      model_mem[sweep_idx] = '0;
      sweep_idx++;
      busy_left--;
    end else begin
      if (acc) begin
        model_mem[int'(wa)] = merge(model_mem[int'(wa)], d, hl);
        ack_q.push_back(tag);
      end
      if (ill) err_q.push_back(tag);
      if (clr) begin
        busy_left = NUM_REGS;
        sweep_idx = 0;
      end
    end
    busy_q.push_back('{tag, {31'd0, busy_left > 0}});
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 32'h0, 2'd0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic wr_only(input logic [3:0] wa, input logic [31:0] d, input logic [1:0] hl);
    step(1'b1, wa, d, hl, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic rd_only(input logic [3:0] ra);
    step(1'b0, 4'd0, 32'h0, 2'd0, 1'b0, 1'b1, ra);
  endtask

  task automatic check_quiet_reset(input string tagname);
    check({tagname, "_clr_busy"}, {31'd0, clr_busy}, 32'd0);
    check({tagname, "_data_out"}, data_out, 32'd0);
    check({tagname, "_ack"}, {31'd0, reg_wr_ack}, 32'd0);
    check({tagname, "_err"}, {31'd0, wr_err}, 32'd0);
    check({tagname, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
  endtask

  // asynchronous reset applied away from the clock edges
  task automatic apply_reset(input string tagname);
    @(negedge clk);
    #1;
    rst_b   = 1'b0;
    reg_wr  = 1'b0;
    reg_clr = 1'b0;
    rd_en   = 1'b0;
    #1;
    check_quiet_reset(tagname);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  // monitor: compares whatever the DUT presents against the queues
  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst_b) begin
      if (busy_q.size() > 0 && busy_q[0].tag == cyc) begin
        e = busy_q.pop_front();
        check("clr_busy", {31'd0, clr_busy}, e.data);
      end
      if (reg_wr_ack) begin
        if (ack_q.size() == 0) check("ack_unexpected", {31'd0, reg_wr_ack}, 32'd0);
        else check("ack_cycle", cyc, ack_q.pop_front());
      end
      while (ack_q.size() > 0 && ack_q[0] <= cyc) begin
        check("ack_missing", {31'd0, reg_wr_ack}, 32'd1);
        void'(ack_q.pop_front());
      end
      if (wr_err) begin
        if (err_q.size() == 0) check("err_unexpected", {31'd0, wr_err}, 32'd0);
        else check("err_cycle", cyc, err_q.pop_front());
      end
      while (err_q.size() > 0 && err_q[0] <= cyc) begin
        check("err_missing", {31'd0, wr_err}, 32'd1);
        void'(err_q.pop_front());
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          check("rd_unexpected", {31'd0, rd_valid}, 32'd0);
        end else begin
          e = rd_q.pop_front();
          check("rd_cycle", cyc, e.tag);
          check("rd_data", data_out, e.data);
        end
      end
      while (rd_q.size() > 0 && rd_q[0].tag <= cyc) begin
        check("rd_missing", {31'd0, rd_valid}, 32'd1);
        void'(rd_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_b   = 1'b0;
    reg_wr  = 1'b0;
    wr_addr = '0;
    data_in = '0;
    hl_sel  = 2'd0;
    reg_clr = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    model_reset();
    #3;
    check_quiet_reset("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_b = 1'b1;

    // reset contents
    for (int i = 0; i < NUM_REGS; i++) rd_only(4'(i));

    // full and lane writes
    wr_only(4'd2, 32'hAAAA_AAAA, 2'd0);
    rd_only(4'd2);
    wr_only(4'd2, 32'hBBBB_BBBB, 2'd1);
    rd_only(4'd2);
    wr_only(4'd2, 32'hCCCC_CCCC, 2'd2);
    rd_only(4'd2);

    // illegal mode and out-of-range address
    wr_only(4'd3, 32'hDEAD_BEEF, 2'd3);
    wr_only(4'd9, 32'hDEAD_BEEF, 2'd0);
    rd_only(4'd3);
    rd_only(4'd9);

    // fill, sweep, read during sweep, write during sweep
    for (int i = 0; i < NUM_REGS; i++) wr_only(4'(i), 32'h1111_1111 * (i + 1), 2'd0);
    step(1'b0, 4'd0, 32'h0, 2'd0, 1'b1, 1'b0, 4'd0);
    idle();
    idle();
    rd_only(4'd7);
    wr_only(4'd6, 32'h5555_5555, 2'd0);
    step(1'b0, 4'd0, 32'h0, 2'd0, 1'b1, 1'b0, 4'd0);
    idle();
    idle();
    idle();
    // first idle cycle: same-cycle write and read of cleared reg 5
    step(1'b1, 4'd5, 32'h1234_5678, 2'd0, 1'b0, 1'b1, 4'd5);
    rd_only(4'd5);
    for (int i = 0; i < NUM_REGS; i++) if (i != 5) rd_only(4'(i));

    // write coinciding with clear request: written then swept
    step(1'b1, 4'd1, 32'h7777_7777, 2'd0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < NUM_REGS; i++) idle();
    rd_only(4'd1);

    // back-to-back writes held high
    for (int i = 0; i < 4; i++) wr_only(4'(i), 32'hA5A5_0000 + i, 2'd0);
    for (int i = 0; i < 4; i++) rd_only(4'(i));

    // reset in the middle of a sweep
    step(1'b0, 4'd0, 32'h0, 2'd0, 1'b1, 1'b0, 4'd0);
    idle();
    idle();
    idle();
    apply_reset("midsweep");
    wr_only(4'd4, 32'h0F0F_F0F0, 2'd0);
    rd_only(4'd4);
    rd_only(4'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), $urandom,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)));
    end

    // drain and confirm every expectation was consumed
    for (int i = 0; i < NUM_REGS + 2; i++) idle();
    @(negedge clk);
    #1;
    check("ack_q_drained", ack_q.size(), 32'd0);
    check("err_q_drained", err_q.size(), 32'd0);
    check("rd_q_drained", rd_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
